// File: rtl/cosim_commit_queue.sv
// Commit-stage capture queue for a cosim checker: compacts up to COMMIT_WIDTH
// retired instructions plus one trap per cycle into program order and drains one per cycle.
module cosim_commit_queue #(
  parameter int COMMIT_WIDTH = 2,
  parameter int XLEN         = 64,
  parameter int INST_LEN     = 32,
  parameter int DEPTH        = 16,
  parameter int HARTID       = 0
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [COMMIT_WIDTH-1:0]         in_valid,
  input  logic [XLEN*COMMIT_WIDTH-1:0]    in_pc,
  input  logic [INST_LEN*COMMIT_WIDTH-1:0] in_inst,
  input  logic [XLEN*COMMIT_WIDTH-1:0]    in_wdata,
  input  logic [XLEN*COMMIT_WIDTH-1:0]    in_mstatus,
  input  logic [COMMIT_WIDTH-1:0]         in_check,
  input  logic                            in_int_xcpt,
  input  logic [XLEN-1:0]                 in_cause,
  output logic                            in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [31:0]                     out_hartid,
  output logic                            out_is_trap,
  output logic [XLEN-1:0]                 out_pc,
  output logic [INST_LEN-1:0]             out_inst,
  output logic [XLEN-1:0]                 out_data,
  output logic [XLEN-1:0]                 out_mstatus,
  output logic                            out_check,
  output logic [$clog2(DEPTH+1)-1:0]      count,
  output logic                            overflow,
  output logic [31:0]                     drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]       head, tail;
  logic [CW-1:0]       lane_cnt, n_evt;
  logic [AW-1:0]       wr_idx [COMMIT_WIDTH];
  logic [AW-1:0]       trap_idx;
  logic                drop, pop;

  logic                mem_trap    [DEPTH];
  logic [XLEN-1:0]     mem_pc      [DEPTH];
  logic [INST_LEN-1:0] mem_inst    [DEPTH];
  logic [XLEN-1:0]     mem_data    [DEPTH];
  logic [XLEN-1:0]     mem_mstatus [DEPTH];
  logic                mem_check   [DEPTH];

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [CW-1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Each valid lane lands at tail plus the number of valid lanes below it; the trap goes last.
  always_comb begin
    lane_cnt = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      wr_idx[i] = tail + lane_cnt[AW-1:0];
      lane_cnt  = lane_cnt + CW'(in_valid[i]);
    end
    trap_idx = tail + lane_cnt[AW-1:0];
    n_evt    = lane_cnt + CW'(in_int_xcpt);
  end

  assign in_ready  = (DEPTH - int'(count)) >= (COMMIT_WIDTH + 1);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign drop      = !in_ready && ((|in_valid) || in_int_xcpt);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (in_ready) tail <= tail + n_evt[AW-1:0];
      if (pop) head <= head + AW'(1);
      count <= count + (in_ready ? n_evt : '0) - CW'(pop);
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= sat_add(drop_count, n_evt);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (in_ready) begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (in_valid[i]) begin
          mem_trap[wr_idx[i]]    <= 1'b0;
          mem_pc[wr_idx[i]]      <= in_pc[i*XLEN +: XLEN];
          mem_inst[wr_idx[i]]    <= in_inst[i*INST_LEN +: INST_LEN];
          mem_data[wr_idx[i]]    <= in_wdata[i*XLEN +: XLEN];
          mem_mstatus[wr_idx[i]] <= in_mstatus[i*XLEN +: XLEN];
          mem_check[wr_idx[i]]   <= in_check[i];
        end
      end
      if (in_int_xcpt) begin
        mem_trap[trap_idx]    <= 1'b1;
        mem_pc[trap_idx]      <= '0;
        mem_inst[trap_idx]    <= '0;
        mem_data[trap_idx]    <= in_cause;
        mem_mstatus[trap_idx] <= '0;
        mem_check[trap_idx]   <= 1'b0;
      end
    end
  end

  // Storage is never reset, so every head field is masked while the queue is empty.
  assign out_hartid  = 32'(HARTID);
  assign out_is_trap = out_valid ? mem_trap[head]    : 1'b0;
  assign out_pc      = out_valid ? mem_pc[head]      : '0;
  assign out_inst    = out_valid ? mem_inst[head]    : '0;
  assign out_data    = out_valid ? mem_data[head]    : '0;
  assign out_mstatus = out_valid ? mem_mstatus[head] : '0;
  assign out_check   = out_valid ? mem_check[head]   : 1'b0;

endmodule

// File: tb/tb_cosim_commit_queue.sv
// Scoreboard bench for cosim_commit_queue: expected entries are queued when
// stimulus is accepted and compared in order as the DUT drains them.
module tb_cosim_commit_queue;

  localparam int W  = 2;
  localparam int XL = 64;
  localparam int IL = 32;
  localparam int D  = 16;

  typedef struct packed {
    logic          trap;
    logic [XL-1:0] pc;
    logic [IL-1:0] inst;
    logic [XL-1:0] data;
    logic [XL-1:0] ms;
    logic          chk;
  } ent_t;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [W-1:0]      in_valid = '0;
  logic [XL*W-1:0]   in_pc = '0;
  logic [IL*W-1:0]   in_inst = '0;
  logic [XL*W-1:0]   in_wdata = '0;
  logic [XL*W-1:0]   in_mstatus = '0;
  logic [W-1:0]      in_check = '0;
  logic              in_int_xcpt = 1'b0;
  logic [XL-1:0]     in_cause = '0;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_hartid;
  logic              out_is_trap;
  logic [XL-1:0]     out_pc;
  logic [IL-1:0]     out_inst;
  logic [XL-1:0]     out_data;
  logic [XL-1:0]     out_mstatus;
  logic              out_check;
  logic [4:0]        count;
  logic              overflow;
  logic [31:0]       drop_count;

  int   total = 0;
  int   bad   = 0;
  int   mcount = 0;
  ent_t sbq[$];
  ent_t mon_e;

  cosim_commit_queue #(.COMMIT_WIDTH(W), .XLEN(XL), .INST_LEN(IL), .DEPTH(D), .HARTID(0)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_wdata(in_wdata), .in_mstatus(in_mstatus), .in_check(in_check),
    .in_int_xcpt(in_int_xcpt), .in_cause(in_cause), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_hartid(out_hartid),
    .out_is_trap(out_is_trap), .out_pc(out_pc), .out_inst(out_inst), .out_data(out_data),
    .out_mstatus(out_mstatus), .out_check(out_check), .count(count),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  // One time unit before each rising edge: check head against the scoreboard.
  always @(negedge clock) begin
    #4;
    if (reset === 1'b1) begin
      total++;
      if (out_valid !== (sbq.size() != 0)) begin
        bad++;
        $display("FAIL out_valid got=%b exp=%b", out_valid, (sbq.size() != 0));
      end
      if (out_ready && sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        total++;
        if ({out_is_trap, out_pc, out_inst, out_data, out_mstatus, out_check} !== mon_e ||
            out_hartid !== 32'd0) begin
          bad++;
          $display("FAIL head got trap=%b pc=%h data=%h hart=%0d exp trap=%b pc=%h data=%h",
                   out_is_trap, out_pc, out_data, out_hartid, mon_e.trap, mon_e.pc, mon_e.data);
        end
      end
    end
  end

  task automatic idle_in();
    in_valid = '0;
    in_int_xcpt = 1'b0;
    in_cause = '0;
  endtask

  task automatic set_lane(input int i, input logic [XL-1:0] pc);
    in_valid[i]            = 1'b1;
    in_pc[i*XL +: XL]      = pc;
    in_inst[i*IL +: IL]    = pc[IL-1:0] ^ 32'h0000_0013;
    in_wdata[i*XL +: XL]   = ~pc;
    in_mstatus[i*XL +: XL] = pc + 64'h1800;
    in_check[i]            = pc[2];
  endtask

  // Advances one clock; the model decides acceptance from its own occupancy.
  task automatic tick();
    int   n;
    logic rdy, pop;
    ent_t grp[$];
    ent_t e;
    n   = 0;
    rdy = (D - mcount) >= (W + 1);
    for (int i = 0; i < W; i++) begin
      if (in_valid[i]) begin
        e.trap = 1'b0;
        e.pc   = in_pc[i*XL +: XL];
        e.inst = in_inst[i*IL +: IL];
        e.data = in_wdata[i*XL +: XL];
        e.ms   = in_mstatus[i*XL +: XL];
        e.chk  = in_check[i];
        grp.push_back(e);
        n++;
      end
    end
    if (in_int_xcpt) begin
      e = '0;
      e.trap = 1'b1;
      e.data = in_cause;
      grp.push_back(e);
      n++;
    end
    pop = (mcount != 0) && out_ready;
    @(posedge clock);
    #1;
    if (rdy) begin
      foreach (grp[k]) sbq.push_back(grp[k]);
      mcount += n;
    end
    if (pop) mcount--;
    @(negedge clock);
    #1;
  endtask

  task automatic drain_all();
    idle_in();
    out_ready = 1'b1;
    for (int k = 0; k < 60 && mcount != 0; k++) tick();
    total++;
    if (count !== 5'd0 || sbq.size() != 0) begin
      bad++;
      $display("FAIL drain count=%0d left=%0d exp 0", count, sbq.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    #1;
    reset = 1'b1;
    tick();
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 5'd0 || overflow !== 1'b0 ||
        drop_count !== 32'd0 || out_pc !== 64'd0 || out_data !== 64'd0) begin
      bad++;
      $display("FAIL reset_state got v=%b rdy=%b cnt=%0d ovf=%b drop=%0d pc=%h exp 0 1 0 0 0 0",
               out_valid, in_ready, count, overflow, drop_count, out_pc);
    end
  endtask

  task automatic test_group_trap();
    out_ready = 1'b1;
    idle_in();
    set_lane(0, 64'h1000);
    set_lane(1, 64'h1004);
    in_int_xcpt = 1'b1;
    in_cause = 64'h8000_0000_0000_0007;
    tick();
    total++;
    if (count !== 5'd3) begin
      bad++;
      $display("FAIL group_count got=%0d exp=3", count);
    end
    total++;
    if (out_pc !== 64'h1000) begin
      bad++;
      $display("FAIL group_first_pc got=%h exp=1000", out_pc);
    end
    drain_all();
  endtask

  task automatic test_sparse_lane();
    out_ready = 1'b0;
    idle_in();
    set_lane(0, 64'hDEAD);
    set_lane(1, 64'h2000);
    in_valid[0] = 1'b0;
    tick();
    idle_in();
    total++;
    if (count !== 5'd1 || out_pc !== 64'h2000) begin
      bad++;
      $display("FAIL sparse got cnt=%0d pc=%h exp cnt=1 pc=2000", count, out_pc);
    end
    drain_all();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      idle_in();
      set_lane(0, 64'h3000 + 64'(8 * k));
      set_lane(1, 64'h3004 + 64'(8 * k));
      tick();
    end
    total++;
    if (count !== 5'd14 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_full got cnt=%0d rdy=%b exp cnt=14 rdy=0", count, in_ready);
    end
    set_lane(0, 64'h4000);
    set_lane(1, 64'h4004);
    tick();
    idle_in();
    total++;
    if (count !== 5'd14 || overflow !== 1'b1 || drop_count !== 32'd2) begin
      bad++;
      $display("FAIL bp_drop got cnt=%0d ovf=%b drop=%0d exp 14 1 2", count, overflow, drop_count);
    end
    tick();
    total++;
    if (out_pc !== 64'h3000 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_stable got pc=%h v=%b exp pc=3000 v=1", out_pc, out_valid);
    end
    drain_all();
  endtask

  task automatic test_wrap();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      idle_in();
      set_lane(0, 64'h5000 + 64'(8 * k));
      set_lane(1, 64'h5004 + 64'(8 * k));
      tick();
    end
    idle_in();
    set_lane(1, 64'h5100);
    tick();
    total++;
    if (count !== 5'd13 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL wrap_13 got cnt=%0d rdy=%b exp cnt=13 rdy=1", count, in_ready);
    end
    out_ready = 1'b1;
    idle_in();
    set_lane(0, 64'h5200);
    set_lane(1, 64'h5204);
    in_int_xcpt = 1'b1;
    in_cause = 64'h0000_0000_0000_000B;
    tick();
    idle_in();
    total++;
    if (count !== 5'd15 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL wrap_15 got cnt=%0d rdy=%b exp cnt=15 rdy=0", count, in_ready);
    end
    total++;
    if (overflow !== 1'b1 || drop_count !== 32'd2) begin
      bad++;
      $display("FAIL sticky got ovf=%b drop=%0d exp 1 2", overflow, drop_count);
    end
    drain_all();
  endtask

  task automatic test_reset_midop();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idle_in();
      set_lane(0, 64'h6000 + 64'(8 * k));
      set_lane(1, 64'h6004 + 64'(8 * k));
      tick();
    end
    idle_in();
    set_lane(0, 64'h6100);
    tick();
    idle_in();
    total++;
    if (count !== 5'd9) begin
      bad++;
      $display("FAIL mid_fill got cnt=%0d exp=9", count);
    end
    reset = 1'b0;
    #1;
    sbq.delete();
    mcount = 0;
    total++;
    if (count !== 5'd0 || out_valid !== 1'b0 || out_pc !== 64'd0 || overflow !== 1'b0 ||
        drop_count !== 32'd0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_reset got cnt=%0d v=%b pc=%h ovf=%b drop=%0d exp all clear",
               count, out_valid, out_pc, overflow, drop_count);
    end
    #1;
    reset = 1'b1;
    @(negedge clock);
    #1;
    set_lane(0, 64'h7000);
    tick();
    idle_in();
    total++;
    if (count !== 5'd1 || out_pc !== 64'h7000) begin
      bad++;
      $display("FAIL post_reset got cnt=%0d pc=%h exp cnt=1 pc=7000", count, out_pc);
    end
    drain_all();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time bound expired");
  end

  initial begin
    test_reset();
    test_group_trap();
    test_sparse_lane();
    test_backpressure();
    test_wrap();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
